// File: rtl/ec_pkg.sv
// Shared types for the XOR-parity erasure decoder: result status, popcount class, FSM states.
package ec_pkg;

  typedef enum logic [1:0] {
    EC_CLEAN         = 2'd0,
    EC_RECOVERED     = 2'd1,
    EC_UNCORRECTABLE = 2'd2,
    EC_PARITY_ERR    = 2'd3
  } ec_status_e;

  typedef enum logic [1:0] {
    POP_ZERO = 2'd0,
    POP_ONE  = 2'd1,
    POP_MANY = 2'd2
  } pop_class_e;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

endpackage

// File: rtl/xor_erasure_decoder_if.sv
// Packet stream in, decode result out; master drives packets and consumes results.
interface xor_erasure_decoder_if #(
  parameter int unsigned PACKET_LENGTH = 2,
  parameter int unsigned INPUT_NUM     = 12
);
  localparam int unsigned IDX_W = $clog2(INPUT_NUM);

  logic [INPUT_NUM-1:0]     erasure_mask;
  logic                     in_valid;
  logic                     in_ready;
  logic [PACKET_LENGTH-1:0] in_packet;
  logic                     out_valid;
  logic                     out_ready;
  logic [PACKET_LENGTH-1:0] out_packet;
  logic [IDX_W-1:0]         out_index;
  logic [1:0]               out_status;

  modport master (
    output erasure_mask, in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_packet, out_index, out_status
  );

  modport slave (
    input  erasure_mask, in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_packet, out_index, out_status
  );
endinterface

// File: rtl/onehot_index_encoder.sv
// Classifies a mask as zero / one / many set bits and reports the lowest set-bit index.
module onehot_index_encoder
  import ec_pkg::*;
#(
  parameter int unsigned N     = 12,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  output pop_class_e       pop_class,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    pop_class = POP_ZERO;
    index     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (pop_class == POP_ZERO) begin
          pop_class = POP_ONE;
          index     = IDX_W'(i);
        end else begin
          pop_class = POP_MANY;
        end
      end
    end
  end

endmodule

// File: rtl/xor_erasure_decoder.sv
// Streaming single-erasure XOR-parity decoder: XORs surviving packets of a frame and
// reports the recovered packet, a parity syndrome, or an uncorrectable status.
module xor_erasure_decoder
  import ec_pkg::*;
#(
  parameter int unsigned PACKET_LENGTH = 2,
  parameter int unsigned INPUT_NUM     = 12,
  localparam int unsigned IDX_W        = $clog2(INPUT_NUM)
) (
  input logic                   clk,
  input logic                   rst,
  xor_erasure_decoder_if.slave  bus
);

  logic [1:0]               state_q;
  logic [PACKET_LENGTH-1:0] acc_q;
  logic [PACKET_LENGTH-1:0] acc_next;
  logic [IDX_W-1:0]         cnt_q;
  logic [INPUT_NUM-1:0]     mask_q;
  logic                     out_valid_q;
  logic [PACKET_LENGTH-1:0] out_packet_q;
  logic [IDX_W-1:0]         out_index_q;
  logic [1:0]               out_status_q;

  logic                     accept;
  logic                     last_beat;
  pop_class_e               pop_class;
  logic [IDX_W-1:0]         set_idx;
  ec_status_e               res_status;
  logic [PACKET_LENGTH-1:0] res_packet;
  logic [IDX_W-1:0]         res_index;

  assign bus.in_ready   = (state_q != OUTPUT);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_packet = out_packet_q;
  assign bus.out_index  = out_index_q;
  assign bus.out_status = out_status_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_beat = (state_q == ACCUM) && (cnt_q == IDX_W'(INPUT_NUM - 1));

  // Erased beats are consumed but contribute nothing to the parity sum.
  assign acc_next = mask_q[cnt_q] ? acc_q : (acc_q ^ bus.in_packet);

  onehot_index_encoder #(
    .N     (INPUT_NUM),
    .IDX_W (IDX_W)
  ) u_enc (
    .mask      (mask_q),
    .pop_class (pop_class),
    .index     (set_idx)
  );

  always_comb begin
    res_status = EC_CLEAN;
    res_packet = '0;
    res_index  = '0;
    case (pop_class)
      POP_ZERO: begin
        res_status = (acc_next == '0) ? EC_CLEAN : EC_PARITY_ERR;
        res_packet = acc_next;
      end
      POP_ONE: begin
        res_status = EC_RECOVERED;
        res_packet = acc_next;
        res_index  = set_idx;
      end
      default: res_status = EC_UNCORRECTABLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      out_valid_q  <= 1'b0;
      out_packet_q <= '0;
      out_index_q  <= '0;
      out_status_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mask_q  <= bus.erasure_mask;
            cnt_q   <= IDX_W'(1);
            acc_q   <= bus.erasure_mask[0] ? '0 : bus.in_packet;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (last_beat) begin
              state_q      <= OUTPUT;
              cnt_q        <= '0;
              acc_q        <= '0;
              out_valid_q  <= 1'b1;
              out_packet_q <= res_packet;
              out_index_q  <= res_index;
              out_status_q <= res_status;
            end else begin
              acc_q <= acc_next;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_erasure_decoder.sv
// Directed bench for xor_erasure_decoder with a frame-level reference model and scoreboard.
module tb_xor_erasure_decoder;
  import ec_pkg::*;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] pkt;
    logic [3:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   results_seen = 0;
  exp_t exp_q[$];
  logic [1:0] last_st, last_pkt;
  logic [3:0] last_idx;

  logic [1:0] fa [12];
  logic [1:0] f3 [12];
  logic [1:0] f5 [12];
  logic [1:0] fb [12];
  logic [1:0] f7 [12];
  exp_t m;

  xor_erasure_decoder_if #(.PACKET_LENGTH(2), .INPUT_NUM(12)) bus ();

  xor_erasure_decoder #(.PACKET_LENGTH(2), .INPUT_NUM(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame-level rule: XOR of surviving packets, classified by erasure count.
  function automatic exp_t model(input logic [11:0] mk, input logic [1:0] p [12]);
    exp_t e;
    logic [1:0] x;
    int pos;
    x = 2'd0;
    pos = 0;
    for (int i = 0; i < 12; i++) begin
      if (mk[i]) pos = i;
      else x = x ^ p[i];
    end
    case ($countones(mk))
      0: begin
        e.st = (x == 2'd0) ? 2'd0 : 2'd3;
        e.pkt = x;
        e.idx = 4'd0;
      end
      1: begin
        e.st = 2'd1;
        e.pkt = x;
        e.idx = 4'(pos);
      end
      default: begin
        e.st = 2'd2;
        e.pkt = 2'd0;
        e.idx = 4'd0;
      end
    endcase
    return e;
  endfunction

  // Scoreboard: every cycle a result is presented it must match the queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", bus.out_valid, 1'b0);
      end else begin
        check("out_status", bus.out_status, exp_q[0].st);
        check("out_packet", bus.out_packet, exp_q[0].pkt);
        check("out_index", bus.out_index, exp_q[0].idx);
        check("in_ready_in_output", bus.in_ready, 1'b0);
        if (bus.out_ready) begin
          last_st = bus.out_status;
          last_pkt = bus.out_packet;
          last_idx = bus.out_index;
          void'(exp_q.pop_front());
          results_seen++;
        end
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic send_frame(input logic [11:0] mk, input logic [1:0] p [12], input int n_beats,
                            input bit gaps, input bit mask_flip);
    bit accepted;
    int guard;
    int k;
    for (int i = 0; i < n_beats; i++) begin
      if (gaps) begin
        k = $urandom_range(0, 2);
        if (k > 0) begin
          bus.in_valid = 1'b0;
          repeat (k) @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_packet = p[i];
      bus.erasure_mask = (i != 0 && mask_flip) ? ~mk : mk;
      accepted = 1'b0;
      guard = 0;
      while (!accepted) begin
        @(negedge clk);
        accepted = bus.in_ready;
        guard++;
        if (guard > 200) begin
          $display("FAIL accept_timeout beat=%0d actual=stalled required=accepted", i);
          $fatal(1);
        end
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.erasure_mask = mk;
    if (n_beats == 12) begin
      exp_q.push_back(model(mk, p));
      @(negedge clk);
      check("latency_out_valid", bus.out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_results(input int n);
    int guard;
    guard = 0;
    while (results_seen < n && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (results_seen < n) check("result_timeout", results_seen, n);
  endtask

  initial begin
    fa = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0};
    f3 = fa; f3[4] = 2'b01;
    f5 = fa; f5[2] = 2'b10;
    fb = fa; fb[0] = 2'd2;
    f7 = fa; f7[1] = 2'd3;

    // Pin the model with hand-derived values.
    m = model(12'h000, fa);
    check("model_clean_st", m.st, 2'd0);
    check("model_clean_pkt", m.pkt, 2'd0);
    m = model(12'h010, f3);
    check("model_single_pkt", m.pkt, 2'b10);
    check("model_single_idx", m.idx, 4'd4);
    m = model(12'h081, fa);
    check("model_double_st", m.st, 2'd2);
    m = model(12'h000, f5);
    check("model_parity_pkt", m.pkt, 2'b01);

    bus.in_valid = 1'b0;
    bus.in_packet = 2'd0;
    bus.erasure_mask = 12'h000;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_packet", bus.out_packet, 2'd0);
    check("rst_out_index", bus.out_index, 4'd0);
    check("rst_out_status", bus.out_status, 2'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Abort mid-frame with reset, then a clean frame must decode without residue.
    send_frame(12'h000, f3, 5, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    send_frame(12'h000, fa, 12, 1'b0, 1'b0);
    wait_results(1);
    check("clean_status", last_st, 2'd0);
    check("clean_packet", last_pkt, 2'd0);

    send_frame(12'h010, f3, 12, 1'b0, 1'b0);
    wait_results(2);
    check("single_status", last_st, 2'd1);
    check("single_index", last_idx, 4'd4);
    check("single_packet", last_pkt, 2'b10);

    send_frame(12'h081, fa, 12, 1'b0, 1'b0);
    wait_results(3);
    check("double_status", last_st, 2'd2);
    check("double_packet", last_pkt, 2'd0);
    check("double_index", last_idx, 4'd0);

    send_frame(12'h000, f5, 12, 1'b0, 1'b0);
    wait_results(4);
    check("parity_status", last_st, 2'd3);
    check("parity_syndrome", last_pkt, 2'b01);

    // Backpressure: result held 5 cycles while the next frame waits for the handshake.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send_frame(12'h800, fb, 12, 1'b1, 1'b1);
    fork
      send_frame(12'h002, f7, 12, 1'b1, 1'b0);
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_results(5);
        check("bp_status", last_st, 2'd1);
        check("bp_index", last_idx, 4'd11);
        check("bp_packet", last_pkt, 2'd3);
      end
    join
    wait_results(6);
    check("after_bp_status", last_st, 2'd1);
    check("after_bp_index", last_idx, 4'd1);
    check("after_bp_packet", last_pkt, 2'd2);

    repeat (5) @(negedge clk);
    check("result_count", results_seen, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
